// File: rtl/dma_defs.sv
// Shared definitions for the dbus word-copy DMA: register offsets, CTRL/STAT
// bit positions and FSM state encodings.
package dma_defs;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_START    = 0;
  localparam int CTRL_IE       = 1;
  localparam int CTRL_ABORT    = 2;
  localparam int CTRL_CLR_DONE = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } dma_state_e;

endpackage

// File: rtl/dma_regs.sv
// Register slave of the DMA: SRC/DST/LEN/IE storage, read mux and
// single-cycle START/ABORT/CLR_DONE pulses decoded from CTRL writes.
module dma_regs
  import dma_defs::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk_bus,
  input  logic              rst,
  input  logic [7:0]        bus_address,
  input  logic [31:0]       bus_data_i,
  input  logic              bus_read,
  input  logic              bus_write,
  output logic [31:0]       bus_data_o,
  input  logic              busy,
  input  logic              done,
  input  logic              aborted,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic [LEN_W-1:0]  len,
  output logic              ie,
  output logic              start_p,
  output logic              abort_p,
  output logic              clr_p
);

  logic [1:0]        sel;
  logic              wr_ctrl;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ie_q, ie_d;
  logic              unused_ok;

  assign sel       = bus_address[3:2];
  assign wr_ctrl   = bus_write && (sel == REG_CTRL);
  assign unused_ok = &{1'b0, bus_read, bus_address[7:4], bus_address[1:0]};

  // START is gated by busy here so the FSM never sees a mid-transfer restart.
  assign start_p = wr_ctrl && bus_data_i[CTRL_START] && !busy;
  assign abort_p = wr_ctrl && bus_data_i[CTRL_ABORT];
  assign clr_p   = wr_ctrl && bus_data_i[CTRL_CLR_DONE];

  always_comb begin
    wr_addr      = ADDR_W'(bus_data_i);
    wr_addr[1:0] = 2'b00;
    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    ie_d  = ie_q;
    if (bus_write) begin
      case (sel)
        REG_SRC: if (!busy) src_d = wr_addr;
        REG_DST: if (!busy) dst_d = wr_addr;
        REG_LEN: if (!busy) len_d = bus_data_i[LEN_W-1:0];
        default: ie_d = bus_data_i[CTRL_IE];
      endcase
    end
  end

  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      ie_q  <= 1'b0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
      ie_q  <= ie_d;
    end
  end

  always_comb begin
    bus_data_o = 32'h0;
    case (sel)
      REG_SRC: bus_data_o = 32'(src_q);
      REG_DST: bus_data_o = 32'(dst_q);
      REG_LEN: bus_data_o = 32'(len_q);
      default: bus_data_o = {28'h0, busy, ie_q, done, aborted};
    endcase
  end

  assign src = src_q;
  assign dst = dst_q;
  assign len = len_q;
  assign ie  = ie_q;

endmodule

// File: rtl/dbus_dma.sv
// Single-channel word-copy DMA: register slave plus a dbus master that moves
// LEN words by alternating read and write beats, then raises a level irq.
module dbus_dma
  import dma_defs::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk_bus,
  input  logic              rst,
  input  logic [7:0]        bus_address,
  input  logic [31:0]       bus_data_i,
  input  logic              bus_read,
  input  logic              bus_write,
  output logic [31:0]       bus_data_o,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic              m_read,
  output logic              m_write,
  output logic [31:0]       m_wrdata,
  input  logic [31:0]       m_rddata,
  input  logic              m_stall,
  output logic              irq,
  output dma_state_e        dbg_state
);

  // Master handshake: a beat completes in any cycle where m_read or m_write
  // is high and m_stall is low; until then address, data and strobe hold.

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cur_src_q, cur_src_d;
  logic [ADDR_W-1:0] cur_dst_q, cur_dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [31:0]       buf_q, buf_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              abort_pend_q, abort_pend_d;

  logic [ADDR_W-1:0] src, dst;
  logic [LEN_W-1:0]  len;
  logic              ie, start_p, abort_p, clr_p;
  logic              busy, rd_done, wr_done;

  assign busy    = (state_q != ST_IDLE);
  assign rd_done = (state_q == ST_RD) && !m_stall;
  assign wr_done = (state_q == ST_WR) && !m_stall;

  dma_regs #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_regs (
    .clk_bus     (clk_bus),
    .rst         (rst),
    .bus_address (bus_address),
    .bus_data_i  (bus_data_i),
    .bus_read    (bus_read),
    .bus_write   (bus_write),
    .bus_data_o  (bus_data_o),
    .busy        (busy),
    .done        (done_q),
    .aborted     (aborted_q),
    .src         (src),
    .dst         (dst),
    .len         (len),
    .ie          (ie),
    .start_p     (start_p),
    .abort_p     (abort_p),
    .clr_p       (clr_p)
  );

  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_p) state_d = (len == '0) ? ST_DONE : ST_RD;
      ST_RD:   if (rd_done) state_d = ST_WR;
      ST_WR:   if (wr_done) state_d = ((rem_q == LEN_W'(1)) || abort_pend_q) ? ST_DONE : ST_RD;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_read       = (state_q == ST_RD);
    m_write      = (state_q == ST_WR);
    m_byteenable = 4'b1111;
    m_address    = '0;
    m_wrdata     = 32'h0;
    if (state_q == ST_RD) m_address = cur_src_q;
    if (state_q == ST_WR) begin
      m_address = cur_dst_q;
      m_wrdata  = buf_q;
    end
  end

  always_comb begin
    cur_src_d    = cur_src_q;
    cur_dst_d    = cur_dst_q;
    rem_d        = rem_q;
    buf_d        = buf_q;
    done_d       = done_q;
    aborted_d    = aborted_q;
    abort_pend_d = abort_pend_q;
    if (clr_p) done_d = 1'b0;
    if (abort_p && (state_q == ST_RD || state_q == ST_WR)) abort_pend_d = 1'b1;
    if (rd_done) begin
      buf_d     = m_rddata;
      cur_src_d = cur_src_q + ADDR_W'(4);
    end
    if (wr_done) begin
      cur_dst_d = cur_dst_q + ADDR_W'(4);
      rem_d     = rem_q - LEN_W'(1);
    end
    if (state_q == ST_DONE) begin
      done_d       = 1'b1;
      aborted_d    = abort_pend_q;
      abort_pend_d = 1'b0;
    end
    // START is only accepted in IDLE, so it cannot collide with the DONE set.
    if (start_p) begin
      cur_src_d    = src;
      cur_dst_d    = dst;
      rem_d        = len;
      done_d       = 1'b0;
      aborted_d    = 1'b0;
      abort_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      cur_src_q    <= '0;
      cur_dst_q    <= '0;
      rem_q        <= '0;
      buf_q        <= 32'h0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      cur_src_q    <= cur_src_d;
      cur_dst_q    <= cur_dst_d;
      rem_q        <= rem_d;
      buf_q        <= buf_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign irq       = done_q & ie;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dbus_dma.sv
// Directed bench for dbus_dma: a stalling memory slave model logs master
// beats, and one linear initial block programs the DMA and checks results.
module tb_dbus_dma;
  import dma_defs::*;

  logic        clk_bus = 1'b0;
  logic        rst;
  logic [7:0]  bus_address;
  logic [31:0] bus_data_i;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_data_o;
  logic [31:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_wrdata;
  logic [31:0] m_rddata;
  logic        m_stall;
  logic        irq;
  dma_state_e  dbg_state;

  int tests  = 0;
  int failed = 0;

  int rd_stall_cfg = 0;
  int wr_stall_cfg = 0;
  int hold_err     = 0;
  int overlap_err  = 0;
  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];

  always #5 clk_bus = ~clk_bus;

  dbus_dma #(.ADDR_W(32), .LEN_W(16)) dut (
    .clk_bus      (clk_bus),
    .rst          (rst),
    .bus_address  (bus_address),
    .bus_data_i   (bus_data_i),
    .bus_read     (bus_read),
    .bus_write    (bus_write),
    .bus_data_o   (bus_data_o),
    .m_address    (m_address),
    .m_byteenable (m_byteenable),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_wrdata     (m_wrdata),
    .m_rddata     (m_rddata),
    .m_stall      (m_stall),
    .irq          (irq),
    .dbg_state    (dbg_state)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hDA7A, a[15:0]};
  endfunction

  // Memory slave: decides stall for the current beat just after each edge
  // and logs a beat when it is going to complete at the next edge.
  initial begin
    int cnt;
    logic held;
    logic [31:0] hold_addr, hold_data;
    cnt = 0;
    held = 1'b0;
    hold_addr = 32'h0;
    hold_data = 32'h0;
    m_stall = 1'b0;
    m_rddata = 32'h0;
    forever begin
      @(posedge clk_bus);
      #1;
      if (m_read && m_write) overlap_err++;
      if (m_read || m_write) begin
        if (held && (m_address !== hold_addr || m_wrdata !== hold_data)) hold_err++;
        m_rddata = m_read ? mem_word(m_address) : 32'h0;
        if (cnt < (m_read ? rd_stall_cfg : wr_stall_cfg)) begin
          m_stall = 1'b1;
          cnt++;
          held = 1'b1;
          hold_addr = m_address;
          hold_data = m_wrdata;
        end else begin
          m_stall = 1'b0;
          cnt = 0;
          held = 1'b0;
          if (m_read) rd_log.push_back(m_address);
          else begin
            wr_addr_log.push_back(m_address);
            wr_data_log.push_back(m_wrdata);
          end
        end
      end else begin
        m_stall = 1'b0;
        m_rddata = 32'h0;
        cnt = 0;
        held = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk_bus);
    bus_address = a;
    bus_data_i  = d;
    bus_write   = 1'b1;
    @(negedge clk_bus);
    bus_write   = 1'b0;
    bus_data_i  = 32'h0;
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
    bus_address = a;
    bus_read    = 1'b1;
    #1;
    d = bus_data_o;
    bus_read    = 1'b0;
  endtask

  task automatic wait_irq(output int k);
    k = 0;
    while (irq !== 1'b1 && k < 200) begin
      @(negedge clk_bus);
      k++;
    end
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int k;
    rst = 1'b1;
    bus_address = 8'h0;
    bus_data_i = 32'h0;
    bus_read = 1'b0;
    bus_write = 1'b0;
    repeat (3) @(negedge clk_bus);
    check("rst_m_read", 32'(m_read), 32'h0);
    check("rst_m_write", 32'(m_write), 32'h0);
    check("rst_m_address", m_address, 32'h0);
    check("rst_m_wrdata", m_wrdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk_bus);
    reg_read(8'h0, rd); check("rst_src", rd, 32'h0);
    reg_read(8'hC, rd); check("rst_stat", rd, 32'h0);
    check("byteenable", 32'(m_byteenable), 32'hF);

    // Basic copy of three words, no stall
    reg_write(8'h0, 32'h0000_1000);
    reg_write(8'h4, 32'h0000_2000);
    reg_write(8'h8, 32'h0000_0003);
    reg_write(8'hC, 32'h0000_0002);
    reg_read(8'hC, rd); check("ie_only_stat", rd, 32'h4);
    clear_logs();
    reg_write(8'hC, 32'h0000_0003);
    check("t1_first_read", 32'(m_read), 32'h1);
    check("t1_first_addr", m_address, 32'h0000_1000);
    wait_irq(k);
    check("t1_irq_latency", 32'(k), 32'd7);
    check("t1_rd_cnt", 32'(rd_log.size()), 32'd3);
    check("t1_rd0", rd_log[0], 32'h1000);
    check("t1_rd1", rd_log[1], 32'h1004);
    check("t1_rd2", rd_log[2], 32'h1008);
    check("t1_wr_cnt", 32'(wr_addr_log.size()), 32'd3);
    check("t1_wa0", wr_addr_log[0], 32'h2000);
    check("t1_wd0", wr_data_log[0], 32'hDA7A_1000);
    check("t1_wa1", wr_addr_log[1], 32'h2004);
    check("t1_wd1", wr_data_log[1], 32'hDA7A_1004);
    check("t1_wa2", wr_addr_log[2], 32'h2008);
    check("t1_wd2", wr_data_log[2], 32'hDA7A_1008);
    reg_read(8'hC, rd); check("t1_stat", rd, 32'h6);
    reg_read(8'h0, rd); check("t1_src_live", rd, 32'h1000);
    reg_read(8'h8, rd); check("t1_len_live", rd, 32'h3);

    // Same copy restarted without reprogramming, writes stall 2 cycles
    clear_logs();
    wr_stall_cfg = 2;
    reg_write(8'hC, 32'h0000_0003);
    check("t2_start_clears_irq", 32'(irq), 32'h0);
    wait_irq(k);
    check("t2_irq_latency", 32'(k), 32'd13);
    check("t2_wr_cnt", 32'(wr_addr_log.size()), 32'd3);
    check("t2_wd2", wr_data_log[2], 32'hDA7A_1008);
    check("t2_hold", 32'(hold_err), 32'h0);
    wr_stall_cfg = 0;
    reg_write(8'hC, 32'h0000_000A);
    reg_read(8'hC, rd); check("clr_done_stat", rd, 32'h4);
    check("clr_done_irq", 32'(irq), 32'h0);

    // LEN = 0
    clear_logs();
    reg_write(8'h8, 32'h0);
    reg_write(8'hC, 32'h0000_000B);
    check("t3_no_read", 32'(m_read), 32'h0);
    @(negedge clk_bus);
    reg_read(8'hC, rd); check("t3_stat", rd, 32'h6);
    check("t3_bus_idle", 32'(rd_log.size() + wr_addr_log.size()), 32'h0);

    // ABORT during the second read stall, LEN = 4
    clear_logs();
    rd_stall_cfg = 3;
    reg_write(8'h8, 32'h4);
    reg_write(8'hC, 32'h0000_0003);
    k = 0;
    while (!(wr_addr_log.size() == 1 && m_read === 1'b1) && k < 100) begin
      @(negedge clk_bus);
      k++;
    end
    check("t4_sync", 32'(k < 100), 32'h1);
    check("t4_in_stall", 32'(m_stall), 32'h1);
    reg_write(8'hC, 32'h0000_0006);
    wait_irq(k);
    check("t4_wr_cnt", 32'(wr_addr_log.size()), 32'd2);
    check("t4_rd_cnt", 32'(rd_log.size()), 32'd2);
    check("t4_wa1", wr_addr_log[1], 32'h2004);
    reg_read(8'hC, rd); check("t4_stat", rd, 32'h7);
    rd_stall_cfg = 0;

    // Address wrap
    clear_logs();
    reg_write(8'h0, 32'hFFFF_FFFC);
    reg_write(8'h4, 32'h0000_3000);
    reg_write(8'h8, 32'h2);
    reg_write(8'hC, 32'h0000_0003);
    wait_irq(k);
    check("t5_irq_latency", 32'(k), 32'd5);
    check("t5_rd1", rd_log[1], 32'h0000_0000);
    check("t5_wd0", wr_data_log[0], 32'hDA7A_FFFC);
    check("t5_wd1", wr_data_log[1], 32'hDA7A_0000);
    check("t5_wa1", wr_addr_log[1], 32'h3004);

    // Register writes and START while busy are ignored
    clear_logs();
    reg_write(8'h0, 32'h0000_1003);
    reg_read(8'h0, rd); check("t6_src_align", rd, 32'h1000);
    reg_write(8'h4, 32'h0000_2000);
    reg_write(8'h8, 32'h2);
    wr_stall_cfg = 2;
    reg_write(8'hC, 32'h0000_0003);
    reg_write(8'h8, 32'h9);
    reg_write(8'h0, 32'h0000_5000);
    reg_write(8'hC, 32'h0000_0003);
    wait_irq(k);
    check("t6_wr_cnt", 32'(wr_addr_log.size()), 32'd2);
    check("t6_rd1", rd_log[1], 32'h1004);
    check("t6_wa1", wr_addr_log[1], 32'h2004);
    reg_read(8'h8, rd); check("t6_len_kept", rd, 32'h2);
    reg_read(8'h0, rd); check("t6_src_kept", rd, 32'h1000);
    check("no_overlap", 32'(overlap_err), 32'h0);

    // Reset in the middle of a stalled write
    clear_logs();
    wr_stall_cfg = 5;
    reg_write(8'hC, 32'h0000_0003);
    k = 0;
    while (m_write !== 1'b1 && k < 100) begin
      @(negedge clk_bus);
      k++;
    end
    check("t7_sync", 32'(k < 100), 32'h1);
    @(negedge clk_bus);
    rst = 1'b1;
    #1;
    check("t7_write_drop", 32'(m_write), 32'h0);
    check("t7_read_low", 32'(m_read), 32'h0);
    check("t7_addr", m_address, 32'h0);
    check("t7_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk_bus);
    rst = 1'b0;
    wr_stall_cfg = 0;
    reg_read(8'h0, rd); check("t7_src", rd, 32'h0);
    reg_read(8'h4, rd); check("t7_dst", rd, 32'h0);
    reg_read(8'h8, rd); check("t7_len", rd, 32'h0);
    reg_read(8'hC, rd); check("t7_stat", rd, 32'h0);
    check("t7_irq", 32'(irq), 32'h0);
    check("t7_no_write", 32'(wr_addr_log.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
